// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: constants shared with the rest of the CPU and the entry
// layout used by the fetch queue.
//   PC_RESET - first valid instruction address (and the idle head PC)
//   IM_LAST  - last word-aligned address inside instruction memory
//   NOP      - instruction word presented when no real instruction is at the head
package fetch_queue_pkg;

  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IM_LAST  = 32'h0000_6FFC;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } fq_entry_t;

  // Instruction-address exception: misaligned or outside instruction memory.
  function automatic logic calc_adel(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < PC_RESET) || (pc > IM_LAST);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: small FIFO that decouples the single-cycle IFU from the
// decoder/controller. Each entry holds {pc, instr, adel}; adel is evaluated
// when the entry is pushed.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   in_valid/in_pc/in_instr, in_ready   - push side (from IFU)
//   out_valid/out_pc/out_instr/out_adel, out_ready - pop side (to decode)
//   flush                 - redirect: drop every entry
//   count                 - current occupancy (0..DEPTH)
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic                     out_adel,
  input  logic                     out_ready,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Storage is deliberately not reset; count masks stale contents.
  fq_entry_t mem_q [DEPTH];
  fq_entry_t head;

  logic push, pop;

  // in_ready looks only at occupancy, so a full queue refuses a push even
  // when decode pops in the same cycle.
  assign in_ready  = (count_q < FULL_CNT);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers are AW bits wide, so increments wrap modulo DEPTH.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset) begin
      mem_q[wr_ptr_q] <= '{pc: in_pc, instr: in_instr, adel: calc_adel(in_pc)};
    end
  end

  assign head = mem_q[rd_ptr_q];

  // Idle head shows a nop at the reset PC; a faulting head keeps its PC but
  // never exposes the fetched word.
  always_comb begin
    out_pc    = PC_RESET;
    out_instr = NOP;
    out_adel  = 1'b0;
    if (out_valid) begin
      out_pc    = head.pc;
      out_adel  = head.adel;
      out_instr = head.adel ? NOP : head.instr;
    end
  end

  assign count = count_q;

endmodule
